ballpark_fanin_tx: RTL and testbench
====================================

Name: ballpark_fanin_tx

Overview:
- Fan-in counterpart to the ballpark fanout timing test: the transmit end of a single-bit serial link.
- Accepts a WIDTH-bit parallel word over a valid/ready handshake and serialises it onto one output pin.
- Frame format: start marker, then data MSB-first, then an optional XOR-reduction parity bit.
- Gives the flow a wide-to-one convergent timing path (mux tree, XOR reduction tree) to check alongside the fanout paths.

Parameters:
- WIDTH, 16, data word width; legal range 2..64.
- PARITY_EN, 1, 1 = append XOR parity bit after data; 0 = no parity bit.
- CNT_W, 8, width of the completed-frame counter.

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in_data  input  WIDTH  parallel word to transmit
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept a word this cycle
- ser_out  output  1  serial data bit
- ser_valid  output  1  ser_out carries a frame bit
- ser_last  output  1  final bit of the current frame
- frame_cnt  output  CNT_W  count of completed frames, wraps

Behaviour:
- Reset values (asynchronous, on reset_n low):
  - outputs: in_ready=0, ser_out=0, ser_valid=0, ser_last=0, frame_cnt=0.
  - internal: state=IDLE, shift register=0, bit counter=0.
- in_ready rises at the first clock edge after reset_n deasserts.
- All outputs are registered; no combinational input-to-output path.
- State machine states: IDLE, START, DATA, PAR.
- IDLE:
  - in_ready=1, ser_valid=0.
  - Accept occurs at edge T when in_valid & in_ready are both sampled high.
  - On accept: latch in_data into the shift register, latch ^in_data as parity, go to START.
- START (cycle after T):
  - ser_valid=1, ser_out=1 (start marker), in_ready=0.
  - Next state: DATA.
- DATA:
  - Runs WIDTH cycles; the bit counter counts WIDTH-1 down to 0.
  - ser_out = latched bit [counter], i.e. MSB first.
  - After the bit-0 cycle: go to PAR if PARITY_EN=1, else IDLE.
- PAR:
  - ser_out = latched parity (1 when the word has an odd number of ones), ser_valid=1.
  - Next state: IDLE.
- ser_last is high for exactly one cycle: the PAR cycle, or the DATA bit-0 cycle when PARITY_EN=0.
- Frame length L = 1 + WIDTH + PARITY_EN cycles with ser_valid high.
- After the ser_last cycle, the block spends one IDLE cycle with ser_valid=0 and in_ready=1.
- Minimum accept-to-accept period is L+1 cycles. With in_valid held high, frames are separated by exactly one ser_valid=0 cycle.
- frame_cnt increments by 1 at the edge ending the ser_last cycle and wraps 2^CNT_W-1 -> 0.
- in_data and in_valid are ignored while in_ready=0. Changing in_data mid-frame does not alter the frame in flight.
- in_valid deasserting without an accept is legal; there is no requirement to hold it.
- Reset mid-frame: outputs go immediately to their reset values. The partial frame is abandoned and never resumed, and frame_cnt is not incremented for it.
- Shift register and parity register update only on accept. Parity is computed from the latched word, not from live in_data.

Test Plan:
- WIDTH=8, PARITY_EN=1, accept 0xA5 -> ser_out over 10 ser_valid cycles = 1,1,0,1,0,0,1,0,1,0 (parity 0); ser_last only on the 10th; frame_cnt 0->1.
- WIDTH=8, accept 0x07 -> data bits 0,0,0,0,0,1,1,1 then parity 1. in_data changed to 0xFF two cycles after accept -> frame unchanged.
- in_valid held high with 0x3C then 0xC3 queued -> second accept exactly 11 cycles after the first; exactly one ser_valid=0 cycle between frames; frame_cnt reaches 2.
- WIDTH=8, PARITY_EN=0, accept 0x80 -> 9-cycle frame 1,1,0,0,0,0,0,0,0; ser_last on the 9th cycle (bit 0).
- reset_n pulsed low during data bit 4 of a frame -> ser_valid=0 and in_ready=0 immediately; in_ready=1 one edge after release; frame_cnt=0; the next accepted word produces a complete, correct frame.
- CNT_W=8, run 256 frames back-to-back -> frame_cnt reads 255 after the 255th frame and 0 after the 256th; no extra ser_last pulses.

Source files
------------

// File: rtl/ballpark_fanin_tx_if.sv
// Handshake and serial-link signals of the fan-in transmitter.
// The slave side is the transmitter; the master side feeds words and watches the pin.
interface ballpark_fanin_tx_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_last;

  modport master (
    output in_data, in_valid,
    input  in_ready, ser_out, ser_valid, ser_last
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, ser_out, ser_valid, ser_last
  );
endinterface

// File: rtl/ballpark_fanin_tx.sv
// Serial transmit end: one parallel word per frame, sent as start marker,
// data MSB-first, then an optional XOR parity bit. Every output is a flop.
module ballpark_fanin_tx #(
  parameter int WIDTH     = 16,
  parameter bit PARITY_EN = 1'b1,
  parameter int CNT_W     = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  ballpark_fanin_tx_if.slave   bus,
  output logic [CNT_W-1:0]     frame_cnt
);

  localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, PAR} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             par_q, par_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             ser_last_q, ser_last_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             accept;

  // in_ready_q gates the accept so the first cycle out of reset never takes a word.
  assign accept = (state_q == IDLE) && in_ready_q && bus.in_valid;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      par_q       <= 1'b0;
      bit_cnt_q   <= '0;
      in_ready_q  <= 1'b0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_last_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      bit_cnt_q   <= bit_cnt_d;
      in_ready_q  <= in_ready_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      ser_last_q  <= ser_last_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    par_d     = par_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
          shift_d = bus.in_data;
          par_d   = ^bus.in_data;
        end
      end
      START: begin
        state_d   = DATA;
        bit_cnt_d = BW'(WIDTH - 1);
      end
      DATA: begin
        if (bit_cnt_q == '0) begin
          state_d = PARITY_EN ? PAR : IDLE;
        end else begin
          bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end
      PAR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they land in flops aligned with it.
  always_comb begin
    in_ready_d  = 1'b0;
    ser_out_d   = 1'b0;
    ser_valid_d = 1'b0;
    ser_last_d  = 1'b0;
    frame_cnt_d = frame_cnt_q + CNT_W'(ser_last_q);
    case (state_d)
      IDLE:  in_ready_d = 1'b1;
      START: begin
        ser_valid_d = 1'b1;
        ser_out_d   = 1'b1;
      end
      DATA: begin
        ser_valid_d = 1'b1;
        ser_out_d   = shift_d[bit_cnt_d];
        ser_last_d  = (PARITY_EN == 1'b0) && (bit_cnt_d == '0);
      end
      PAR: begin
        ser_valid_d = 1'b1;
        ser_out_d   = par_d;
        ser_last_d  = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.ser_out   = ser_out_q;
  assign bus.ser_valid = ser_valid_q;
  assign bus.ser_last  = ser_last_q;
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_ballpark_fanin_tx.sv
// Bench for ballpark_fanin_tx: one parity and one no-parity instance (WIDTH=8),
// a frame-list model compared every cycle, plus hand-computed frame literals.
module tb_ballpark_fanin_tx;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] fc_p, fc_n;

  ballpark_fanin_tx_if #(.WIDTH(8)) ifp ();
  ballpark_fanin_tx_if #(.WIDTH(8)) ifn ();

  ballpark_fanin_tx #(.WIDTH(8), .PARITY_EN(1'b1), .CNT_W(8)) dut_p (
    .clock(clock), .reset_n(reset_n), .bus(ifp), .frame_cnt(fc_p)
  );
  ballpark_fanin_tx #(.WIDTH(8), .PARITY_EN(1'b0), .CNT_W(8)) dut_n (
    .clock(clock), .reset_n(reset_n), .bus(ifn), .frame_cnt(fc_n)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Model: a frame is a list of bits; the link is ready whenever the list is drained.
  bit e_ready[2], e_valid[2], e_out[2], e_last[2];
  int e_cnt[2];
  bit fbits[2][16];
  int flen[2], fpos[2];

  task automatic model_reset(int k);
    e_ready[k] = 0; e_valid[k] = 0; e_out[k] = 0; e_last[k] = 0;
    e_cnt[k] = 0; flen[k] = 0; fpos[k] = 0;
  endtask

  task automatic model_step(int k, bit v, logic [7:0] d, bit pe);
    bit was_ready = e_ready[k];
    if (e_last[k]) e_cnt[k] = (e_cnt[k] + 1) % 256;
    if (was_ready && v) begin
      fbits[k][0] = 1'b1;
      for (int i = 0; i < 8; i++) fbits[k][1+i] = d[7-i];
      flen[k] = 9;
      if (pe) begin
        fbits[k][9] = ($countones(d) % 2) == 1;
        flen[k] = 10;
      end
      fpos[k] = 0;
    end
    if (fpos[k] < flen[k]) begin
      e_valid[k] = 1; e_out[k] = fbits[k][fpos[k]];
      e_last[k] = (fpos[k] == flen[k] - 1); e_ready[k] = 0;
      fpos[k]++;
    end else begin
      e_valid[k] = 0; e_out[k] = 0; e_last[k] = 0; e_ready[k] = 1;
    end
  endtask

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0, ifp.in_valid, ifp.in_data, 1'b1);
      model_step(1, ifn.in_valid, ifn.in_data, 1'b0);
    end
  end

  always @(negedge clock) begin
    chk("p_in_ready",  32'(ifp.in_ready),  32'(e_ready[0]));
    chk("p_ser_valid", 32'(ifp.ser_valid), 32'(e_valid[0]));
    chk("p_ser_out",   32'(ifp.ser_out),   32'(e_out[0]));
    chk("p_ser_last",  32'(ifp.ser_last),  32'(e_last[0]));
    chk("p_frame_cnt", 32'(fc_p),          32'(e_cnt[0]));
    chk("n_in_ready",  32'(ifn.in_ready),  32'(e_ready[1]));
    chk("n_ser_valid", 32'(ifn.ser_valid), 32'(e_valid[1]));
    chk("n_ser_out",   32'(ifn.ser_out),   32'(e_out[1]));
    chk("n_ser_last",  32'(ifn.ser_last),  32'(e_last[1]));
    chk("n_frame_cnt", 32'(fc_n),          32'(e_cnt[1]));
  end

  task automatic drive(int k, bit v, logic [7:0] d);
    if (k == 0) begin ifp.in_valid = v; ifp.in_data = d; end
    else        begin ifn.in_valid = v; ifn.in_data = d; end
  endtask

  function automatic bit rdy(int k);
    return (k == 0) ? ifp.in_ready : ifn.in_ready;
  endfunction

  // Presents a word and returns just after the accepting edge, valid dropped.
  task automatic send(int k, logic [7:0] d);
    bit ok = 0;
    @(negedge clock);
    #2 drive(k, 1'b1, d);
    for (int n = 0; n < 40 && !ok; n++) begin
      if (rdy(k)) ok = 1;
      else @(negedge clock);
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout_%0d: in_ready got 0, required 1", k);
    end
    @(posedge clock);
    #1 drive(k, 1'b0, d);
  endtask

  task automatic collect(int k, int n, int poke, output logic [15:0] bits,
                         output logic [15:0] lasts, output logic [15:0] vals);
    bits = '0; lasts = '0; vals = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      bits  = {bits[14:0],  (k == 0) ? ifp.ser_out   : ifn.ser_out};
      lasts = {lasts[14:0], (k == 0) ? ifp.ser_last  : ifn.ser_last};
      vals  = {vals[14:0],  (k == 0) ? ifp.ser_valid : ifn.ser_valid};
      if (i == poke) #2 drive(k, 1'b1, 8'hFF);
      if (poke >= 0 && i == poke + 5) #2 drive(k, 1'b0, 8'hFF);
    end
    $display("frame inst=%0d: bits=%b last=%b valid=%b", k, bits, lasts, vals);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [15:0] bits, lasts, vals;
  int          n_cyc, zeros, lasts_seen, extra;
  bit          ok, chk255;

  initial begin
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    repeat (2) @(negedge clock);
    chk("rst_p_in_ready", 32'(ifp.in_ready), 0);
    chk("rst_p_ser_valid", 32'(ifp.ser_valid), 0);
    chk("rst_p_frame_cnt", 32'(fc_p), 0);
    chk("rst_n_in_ready", 32'(ifn.in_ready), 0);
    #2 reset_n = 1'b1;
    @(negedge clock);
    chk("ready_after_release", 32'(ifp.in_ready), 1);

    // 0xA5 with parity: 1,10100101,0
    send(0, 8'hA5);
    collect(0, 10, -1, bits, lasts, vals);
    chk("a5_bits", 32'(bits), 32'h34A);
    chk("a5_last", 32'(lasts), 32'h001);
    chk("a5_valid", 32'(vals), 32'h3FF);
    @(negedge clock);
    chk("a5_cnt", 32'(fc_p), 1);
    chk("a5_gap_valid", 32'(ifp.ser_valid), 0);

    // 0x07, in_data poked to 0xFF mid-frame: 1,00000111,1
    send(0, 8'h07);
    collect(0, 10, 1, bits, lasts, vals);
    chk("07_bits", 32'(bits), 32'h20F);
    chk("07_last", 32'(lasts), 32'h001);

    // Back-to-back 0x3C then 0xC3 with in_valid held
    @(negedge clock);
    #2 drive(0, 1'b1, 8'h3C);
    ok = 0;
    for (int n = 0; n < 40 && !ok; n++) begin
      if (ifp.in_ready) ok = 1;
      else @(negedge clock);
    end
    @(posedge clock);
    #1 drive(0, 1'b1, 8'hC3);
    n_cyc = 0; zeros = 0;
    do begin
      @(negedge clock);
      n_cyc++;
      if (!ifp.ser_valid) zeros++;
    end while (!ifp.in_ready && n_cyc < 40);
    chk("b2b_period", 32'(n_cyc), 11);
    chk("b2b_gap_cycles", 32'(zeros), 1);
    @(posedge clock);
    #1 drive(0, 1'b0, 8'hC3);
    collect(0, 10, -1, bits, lasts, vals);
    chk("c3_bits", 32'(bits), 32'h386);
    @(negedge clock);
    chk("b2b_cnt", 32'(fc_p), 4);

    // No-parity instance, 0x80: 1,10000000
    send(1, 8'h80);
    collect(1, 9, -1, bits, lasts, vals);
    chk("n80_bits", 32'(bits), 32'h180);
    chk("n80_last", 32'(lasts), 32'h001);
    chk("n80_valid", 32'(vals), 32'h1FF);
    @(negedge clock);
    chk("n80_cnt", 32'(fc_n), 1);

    // Reset during data bit 4 of 0x5A
    send(0, 8'h5A);
    collect(0, 5, -1, bits, lasts, vals);
    chk("5a_partial", 32'(bits), 32'h15);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_ser_valid", 32'(ifp.ser_valid), 0);
    chk("midrst_in_ready", 32'(ifp.in_ready), 0);
    chk("midrst_cnt", 32'(fc_p), 0);
    @(negedge clock);
    #2 reset_n = 1'b1;
    #1 chk("rel_ready_low", 32'(ifp.in_ready), 0);
    @(negedge clock);
    chk("rel_ready_high", 32'(ifp.in_ready), 1);
    send(0, 8'h5A);
    collect(0, 10, -1, bits, lasts, vals);
    chk("5a_bits", 32'(bits), 32'h2B4);
    @(negedge clock);
    chk("5a_cnt", 32'(fc_p), 1);

    // 256 back-to-back frames: counter wraps to 0
    @(negedge clock);
    #2 reset_n = 1'b0;
    @(negedge clock);
    #2 reset_n = 1'b1;
    drive(0, 1'b1, 8'h11);
    lasts_seen = 0; ok = 0; chk255 = 0;
    for (int n = 0; n < 3000 && !ok; n++) begin
      @(negedge clock);
      if (chk255) begin
        chk("cnt_after_255", 32'(fc_p), 255);
        chk255 = 0;
      end
      if (ifp.ser_last) begin
        lasts_seen++;
        if (lasts_seen == 255) chk255 = 1;
        if (lasts_seen == 256) ok = 1;
      end
      #2 if (ok) drive(0, 1'b0, 8'h00);
         else    drive(0, 1'b1, 8'(n * 29 + 5));
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wrap_timeout: frames got %0d, required 256", lasts_seen);
    end
    @(negedge clock);
    chk("cnt_after_256", 32'(fc_p), 0);
    extra = 0;
    repeat (20) begin
      @(negedge clock);
      if (ifp.ser_last) extra++;
    end
    chk("extra_last", 32'(extra), 0);
    $display("wrap run: %0d frames observed", lasts_seen);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
